// File: rtl/servant_uart_mon.sv
// servant_uart_mon: UART 8N1 receiver on the servant GPIO line, buffering decoded
// bytes in a small FIFO behind a valid/ready port with framing and overflow flags.
module servant_uart_mon #(
    parameter int CLKS_PER_BIT = 278,
    parameter int DEPTH        = 16
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst_n,
    input  logic                     i_rx,
    output logic [7:0]               o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_frame_err,
    output logic                     o_overflow,
    input  logic                     i_clr_ovf,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [1:0]    rx_q;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          push, pop, full, wr_en;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge wb_clk or negedge wb_rst_n)
        if (!wb_rst_n) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n = rst_sync[1];
    assign rx_s  = rx_q[1];

    assign o_level = wr_ptr - rd_ptr;
    assign full    = o_level == (AW+1)'(DEPTH);
    assign o_valid = o_level != '0;
    assign pop     = o_valid & i_ready;
    assign push    = state == STOP && cnt == '0 && rx_s;
    assign wr_en   = push && (!full || pop);
    assign o_data  = o_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge wb_clk or negedge rst_n)
        if (!rst_n) begin
            rx_q        <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_frame_err <= 1'b0;
        end else begin
            rx_q        <= {rx_q[0], i_rx};
            o_frame_err <= 1'b0;
            case (state)
                IDLE:
                    if (!rx_s) begin
                        cnt   <= CW'(CLKS_PER_BIT / 2 - 1);
                        state <= START;
                    end
                START:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (rx_s) state <= IDLE;
                    else begin
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        idx   <= '0;
                        state <= DATA;
                    end
                DATA:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) state <= STOP;
                    end
                STOP:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (rx_s) state <= IDLE;
                    else begin
                        o_frame_err <= 1'b1;
                        state       <= BREAK;
                    end
                BREAK:
                    if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end

    always_ff @(posedge wb_clk)
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shift;

    // A push into a full FIFO is still accepted when a pop frees the slot that cycle.
    always_ff @(posedge wb_clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) o_overflow <= 1'b1;
            else if (i_clr_ovf)       o_overflow <= 1'b0;
        end
endmodule

// File: tb/tb_servant_uart_mon.sv
// tb_servant_uart_mon: drives 8N1 frames into servant_uart_mon and checks the
// received byte stream, flags and FIFO level against a queue-based model.
module tb_servant_uart_mon;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          wb_clk = 0, wb_rst_n = 0, i_rx = 1, i_ready = 1, i_clr_ovf = 0;
    logic [7:0]    o_data;
    logic          o_valid, o_frame_err, o_overflow;
    logic [LW-1:0] o_level;

    int         tests_run = 0, fails = 0, ferr_cnt = 0, vcyc = 0, exp_ferr = 0;
    logic [7:0] got[$], exp[$], mq[$];
    bit         m_ovf;

    always #5 wb_clk = ~wb_clk;

    servant_uart_mon #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .i_rx(i_rx), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_frame_err(o_frame_err),
        .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf), .o_level(o_level)
    );

    // Consumer side: record every accepted byte and every frame error pulse.
    always @(negedge wb_clk) begin
        if (o_valid && i_ready) got.push_back(o_data);
        if (o_frame_err) ferr_cnt++;
        if (o_valid) vcyc++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge wb_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop = 1, input int ready_at = -1,
                        input int ncyc = 10 * CPB);
        for (int c = 0; c < ncyc; c++) begin
            i_rx = (c < CPB) ? 1'b0 : (c < 9 * CPB) ? b[(c - CPB) / CPB] : stop;
            if (ready_at >= 0 && c == ready_at) i_ready = 1;
            else if (ready_at >= 0 && c == ready_at + 1) i_ready = 0;
            cyc(1);
        end
    endtask

    // Model FIFO: bytes land in the consumer stream when ready, else queue up to DEPTH.
    task automatic m_push(input logic [7:0] b);
        if (i_ready) exp.push_back(b);
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1;
    endtask

    task automatic m_drain();
        while (mq.size() > 0) exp.push_back(mq.pop_front());
    endtask

    task automatic clear();
        got.delete(); exp.delete(); mq.delete();
        m_ovf = 0; ferr_cnt = 0; vcyc = 0; exp_ferr = 0;
    endtask

    task automatic test_reset();
        cyc(3);
        tests_run++;
        if (o_valid !== 1'b0 || o_level !== '0 || o_data !== 8'h00 || o_frame_err !== 1'b0 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset: valid=%b level=%0d data=%h ferr=%b ovf=%b, required all zero",
                     o_valid, o_level, o_data, o_frame_err, o_overflow);
        end
        wb_rst_n = 1;
        cyc(5);
        tests_run++;
        if (o_valid !== 1'b0 || o_level !== '0) begin
            fails++;
            $display("FAIL reset_release: valid=%b level=%0d, required 0/0", o_valid, o_level);
        end
    endtask

    task automatic test_back_to_back();
        clear();
        i_ready = 1;
        send(8'h55); m_push(8'h55);
        send(8'hA3); m_push(8'hA3);
        cyc(4);
        tests_run++;
        if (got.size() != exp.size()) begin
            fails++;
            $display("FAIL b2b_count: got %0d bytes, required %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            tests_run++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL b2b_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
        tests_run++;
        if (vcyc != 2 || ferr_cnt != 0 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_flags: valid_cycles=%0d ferr=%0d ovf=%b, required 2/0/0", vcyc, ferr_cnt, o_overflow);
        end
    endtask

    task automatic test_glitch();
        clear();
        i_rx = 0;
        cyc(5);
        i_rx = 1;
        cyc(30);
        tests_run++;
        if (got.size() != 0 || ferr_cnt != 0) begin
            fails++;
            $display("FAIL glitch: bytes=%0d ferr=%0d, required 0/0", got.size(), ferr_cnt);
        end
        send(8'h3C);
        cyc(4);
        tests_run++;
        if (got.size() != 1 || got[0] !== 8'h3C) begin
            fails++;
            $display("FAIL glitch_after: bytes=%0d first=%h, required 1 byte 3c", got.size(), got.size() ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_frame_err();
        clear();
        send(8'h41, 0);
        i_rx = 0;
        cyc(100);
        i_rx = 1;
        cyc(20);
        tests_run++;
        if (ferr_cnt != 1 || got.size() != 0) begin
            fails++;
            $display("FAIL frame_err: pulses=%0d bytes=%0d, required 1/0", ferr_cnt, got.size());
        end
        send(8'h42);
        cyc(4);
        tests_run++;
        if (got.size() != 1 || got[0] !== 8'h42 || ferr_cnt != 1) begin
            fails++;
            $display("FAIL frame_err_recover: bytes=%0d first=%h pulses=%0d, required 1 byte 42, 1 pulse",
                     got.size(), got.size() ? got[0] : 8'hxx, ferr_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        clear();
        i_ready = 1;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                send(b, 0);
                exp_ferr++;
                i_rx = 1;
                cyc(4 + $urandom_range(0, 10));
            end else begin
                send(b);
                m_push(b);
                cyc($urandom_range(0, 20));
            end
        end
        cyc(4);
        tests_run++;
        if (got.size() != exp.size() || ferr_cnt != exp_ferr) begin
            fails++;
            $display("FAIL random_count: bytes=%0d pulses=%0d, required %0d/%0d", got.size(), ferr_cnt, exp.size(), exp_ferr);
        end else foreach (exp[i]) begin
            tests_run++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL random_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        clear();
        i_ready = 0;
        for (int b = 1; b <= 5; b++) begin
            send(8'(b));
            m_push(8'(b));
        end
        cyc(4);
        tests_run++;
        if (o_level !== LW'(mq.size()) || o_overflow !== m_ovf) begin
            fails++;
            $display("FAIL ovf_full: level=%0d ovf=%b, required %0d/%b", o_level, o_overflow, mq.size(), m_ovf);
        end
        i_ready = 1;
        cyc(6);
        m_drain();
        tests_run++;
        if (got.size() != exp.size()) begin
            fails++;
            $display("FAIL ovf_drain_count: got %0d bytes, required %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            tests_run++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL ovf_drain_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
        tests_run++;
        if (o_level !== '0 || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: level=%0d ovf=%b, required 0/1", o_level, o_overflow);
        end
        i_clr_ovf = 1;
        cyc(1);
        i_clr_ovf = 0;
        tests_run++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b, required 0", o_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        clear();
        i_ready = 0;
        for (int b = 1; b <= 4; b++) begin
            send(8'(b));
            m_push(8'(b));
        end
        cyc(2);
        tests_run++;
        if (o_level !== 3'd4) begin
            fails++;
            $display("FAIL pp_fill: level=%0d, required 4", o_level);
        end
        // Stop bit is sampled 154 cycles after the start edge is driven.
        send(8'h06, 1, 154);
        exp.push_back(mq.pop_front());
        mq.push_back(8'h06);
        cyc(3);
        tests_run++;
        if (o_level !== 3'd4 || o_overflow !== 1'b0 || got.size() != 1) begin
            fails++;
            $display("FAIL pp_same_cycle: level=%0d ovf=%b pops=%0d, required 4/0/1", o_level, o_overflow, got.size());
        end
        i_ready = 1;
        cyc(6);
        m_drain();
        tests_run++;
        if (got.size() != exp.size()) begin
            fails++;
            $display("FAIL pp_drain_count: got %0d bytes, required %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            tests_run++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL pp_byte%0d: got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear();
        i_ready = 0;
        send(8'h11);
        send(8'h22);
        cyc(2);
        tests_run++;
        if (o_level !== 3'd2) begin
            fails++;
            $display("FAIL rst_mid_fill: level=%0d, required 2", o_level);
        end
        send(8'h7E, 1, -1, 80);
        wb_rst_n = 0;
        #1;
        tests_run++;
        if (o_valid !== 1'b0 || o_level !== '0) begin
            fails++;
            $display("FAIL rst_mid_async: valid=%b level=%0d, required 0/0", o_valid, o_level);
        end
        i_rx = 1;
        cyc(3);
        wb_rst_n = 1;
        cyc(5);
        clear();
        i_ready = 1;
        send(8'h7E);
        cyc(4);
        tests_run++;
        if (got.size() != 1 || got[0] !== 8'h7E || ferr_cnt != 0) begin
            fails++;
            $display("FAIL rst_mid_resend: bytes=%0d first=%h ferr=%0d, required 1 byte 7e, 0 ferr",
                     got.size(), got.size() ? got[0] : 8'hxx, ferr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_random();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/servant_uart_mon.md
Name: servant_uart_mon

Overview:
- Serial monitor/receiver directly downstream of the servant SoC's GPIO output `q`. The firmware bit-bangs UART 8N1 on that pin.
- The block decodes the serial line into bytes and buffers them in a small FIFO.
- It presents bytes on a valid/ready interface for the simulation harness (console print, compare against expected string).
- It flags framing errors and FIFO overflow.

Parameters:
- CLKS_PER_BIT, 278, wb_clk cycles per UART bit (32 MHz / 115200); must be >= 8.
- DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- wb_clk  input  1  system clock; all logic on rising edge.
- wb_rst_n  input  1  asynchronous active-low reset.
- i_rx  input  1  serial line (SoC `q`); idle high; asynchronous to the bit grid.
- o_data  output  8  head-of-FIFO byte; valid only while o_valid=1.
- o_valid  output  1  FIFO not empty.
- i_ready  input  1  consumer accepts o_data when o_valid & i_ready (pop).
- o_frame_err  output  1  one-cycle pulse on bad stop bit.
- o_overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- i_clr_ovf  input  1  synchronous clear of o_overflow.
- o_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert internally):
  - State IDLE.
  - FIFO empty: o_valid=0, o_level=0, o_data=0.
  - o_frame_err=0, o_overflow=0.
  - Synchronizer flops set to 1 (idle line).
  - Reset mid-frame discards the partial byte and FIFO contents.
- Input path: 2-flop synchronizer on i_rx → rx_s. All decisions use rx_s, so there is 2 cycles of latency from pin to logic.
- Bit counter: down-counter, width $clog2(CLKS_PER_BIT); a bit index 0..7; an 8-bit shift register.
- FSM:
  - IDLE: when rx_s=0, load counter with CLKS_PER_BIT/2 - 1 → START.
  - START: at counter 0, sample rx_s.
    - If 1 (glitch): → IDLE, nothing recorded.
    - If 0: load CLKS_PER_BIT-1, bit index 0 → DATA.
  - DATA: at each counter 0, shift rx_s in LSB-first and reload the counter. After bit index 7 is sampled: reload → STOP.
  - STOP: at counter 0, sample rx_s.
    - If 1: push the byte → IDLE.
    - If 0: o_frame_err=1 for exactly that cycle, byte discarded → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. A held-low line yields exactly one frame_err, not a stream.
- Sampling: each data bit is sampled at nominal bit centre = start edge + (k+1.5)*CLKS_PER_BIT cycles, ±1 cycle, plus synchronizer delay.
- Push timing: byte written at the clock edge ending the stop-sample cycle. o_valid/o_level reflect it from the next cycle.
- FIFO:
  - Circular buffer with rd/wr pointers one bit wider than the address.
  - full = level==DEPTH.
  - Pop: occurs when o_valid & i_ready. o_data advances next cycle.
  - o_data is combinational from the head entry, so it is stable while o_valid=1 and no pop occurs.
  - Push and pop in the same cycle: level unchanged. This is allowed even when full; the push is accepted and no overflow is set.
  - Push when full with no pop: byte dropped, o_overflow←1, level stays DEPTH.
  - Pop when empty: ignored.
- o_overflow: set/clear in the same cycle resolves to set. i_clr_ovf has no other effect.
- The receiver never stalls on the FIFO; decoding continues regardless of i_ready.
- Back-to-back frames: a start bit immediately after the stop-sample (IDLE sees 0 on the next cycle) is accepted.

Test Plan:
- CLKS_PER_BIT=16, DEPTH=4, i_ready=1. Send 0x55 then 0xA3 back-to-back → o_data 0x55 then 0xA3, each with a one-cycle o_valid. o_frame_err and o_overflow stay 0.
- Low pulse of 5 cycles on an idle line → no byte, no frame_err, FSM back in IDLE.
- Send 0x41 with stop bit 0, then hold the line low 100 cycles → exactly one o_frame_err pulse, no push. Next 0x42 after the line returns high is received correctly.
- i_ready=0, send 5 bytes 0x01..0x05 → o_level reaches 4, o_overflow=1, byte 0x05 dropped. i_ready=1 then pops 0x01..0x04 in order. i_clr_ovf clears the flag.
- FIFO full; assert i_ready on the exact stop-sample cycle of byte 0x06 → pop 0x01 and push 0x06 together. o_level stays 4, o_overflow stays 0.
- Assert wb_rst_n=0 mid-DATA of 0x7E with 2 bytes buffered → o_valid=0 and o_level=0 immediately (async). After release, 0x7E resent is received cleanly.
